// File: rtl/gpmc_pkg.sv
// Shared types and constants for the synchronous GPMC initiator.
package gpmc_pkg;

  localparam int GPMC_AD_WIDTH    = 16;
  localparam int GPMC_RD_WAIT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    END
  } gpmc_state_t;

endpackage

// File: rtl/gpmc_sync_master.sv
// Synchronous address/data-multiplexed GPMC initiator with a single-outstanding
// request/response host port; gpmc_clk runs at clk/2 and bus outputs move on its rising edge.
module gpmc_sync_master
  import gpmc_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RD_WAIT    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_WIDTH:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     gpmc_clk,
  output logic                     gpmc_cs_n,
  output logic                     gpmc_adv_n,
  output logic                     gpmc_we_n,
  output logic                     gpmc_oe_n,
  output logic [GPMC_AD_WIDTH-1:0] gpmc_ad_out,
  output logic                     gpmc_ad_oe,
  input  logic [GPMC_AD_WIDTH-1:0] gpmc_ad_in
);

  localparam int                   WAIT_BITS = $clog2(GPMC_RD_WAIT_MAX + 1);
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(RD_WAIT);

  gpmc_state_t              state;
  gpmc_state_t              next_state;
  logic                     pending;
  logic                     write_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [WAIT_BITS-1:0]     wait_cnt;
  logic                     rise;
  logic                     last_wait;
  logic                     cs_n_d;
  logic                     adv_n_d;
  logic                     we_n_d;
  logic                     oe_n_d;
  logic                     ad_oe_d;
  logic [GPMC_AD_WIDTH-1:0] ad_out_d;
  logic                     unused_ok;

  // Byte-address bit 0 is dropped; upper AD input bits are unused when DATA_WIDTH < 16.
  assign unused_ok = ^{req_addr[0], gpmc_ad_in};

  assign rise      = ~gpmc_clk;
  assign req_ready = (state == IDLE) && !pending;
  assign last_wait = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (rise) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pending) next_state = ADDR;
      ADDR:    next_state = DATA;
      DATA:    if (write_q || last_wait) next_state = END;
      END:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus levels are decoded from the state being entered so they register on the same rise edge.
  always_comb begin
    cs_n_d   = 1'b1;
    adv_n_d  = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    case (next_state)
      ADDR: begin
        cs_n_d   = 1'b0;
        adv_n_d  = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = GPMC_AD_WIDTH'(addr_q);
      end
      DATA: begin
        cs_n_d = 1'b0;
        if (write_q) begin
          we_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = GPMC_AD_WIDTH'(wdata_q);
        end else begin
          oe_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpmc_cs_n   <= 1'b1;
      gpmc_adv_n  <= 1'b1;
      gpmc_we_n   <= 1'b1;
      gpmc_oe_n   <= 1'b1;
      gpmc_ad_oe  <= 1'b0;
      gpmc_ad_out <= '0;
    end else if (rise) begin
      gpmc_cs_n   <= cs_n_d;
      gpmc_adv_n  <= adv_n_d;
      gpmc_we_n   <= we_n_d;
      gpmc_oe_n   <= oe_n_d;
      gpmc_ad_oe  <= ad_oe_d;
      gpmc_ad_out <= ad_out_d;
    end
  end

  // Read data is captured on the fall edge of the final DATA cycle, where the responder has settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpmc_clk  <= 1'b0;
      pending   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      gpmc_clk  <= ~gpmc_clk;
      rsp_valid <= 1'b0;
      if (req_valid && req_ready) begin
        pending <= 1'b1;
        write_q <= req_write;
        addr_q  <= req_addr[ADDR_WIDTH:1];
        wdata_q <= req_wdata;
      end
      if (rise) begin
        if ((state == IDLE) && (next_state == ADDR)) pending <= 1'b0;
        wait_cnt  <= ((state == DATA) && (next_state == DATA)) ? wait_cnt + 1'b1 : '0;
        rsp_valid <= (next_state == END) && (state != END);
      end else if ((state == DATA) && !write_q && last_wait) begin
        rsp_rdata <= gpmc_ad_in[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_gpmc_sync_master.sv
// Scoreboard bench for gpmc_sync_master: a GPMC responder model plus queued expected bus
// phases and responses, checked by monitors decoupled from the stimulus.
module tb_gpmc_sync_master;

  localparam int RD_WAIT = 2;

  typedef struct {
    logic        write;
    logic [15:0] word;
    logic [15:0] wdata;
  } bus_t;

  typedef struct {
    logic [15:0] rdata;
    int          accept;
    int          lat_min;
    int          lat_max;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   clk_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) clk_count <= clk_count + 1;

  // Main DUT (RD_WAIT = 2)
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [16:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        gpmc_clk, gpmc_cs_n, gpmc_adv_n, gpmc_we_n, gpmc_oe_n, gpmc_ad_oe;
  logic [15:0] gpmc_ad_out;
  logic [15:0] gpmc_ad_in = 16'hDEAD;

  // Second DUT (RD_WAIT = 0)
  logic        req_valid_0 = 1'b0;
  logic        req_ready_0;
  logic        req_write_0 = 1'b0;
  logic [16:0] req_addr_0  = '0;
  logic [15:0] req_wdata_0 = '0;
  logic        rsp_valid_0;
  logic [15:0] rsp_rdata_0;
  logic        gpmc_clk_0, gpmc_cs_n_0, gpmc_adv_n_0, gpmc_we_n_0, gpmc_oe_n_0, gpmc_ad_oe_0;
  logic [15:0] gpmc_ad_out_0;
  logic [15:0] gpmc_ad_in_0 = 16'hFFFF;

  gpmc_sync_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .gpmc_clk(gpmc_clk), .gpmc_cs_n(gpmc_cs_n), .gpmc_adv_n(gpmc_adv_n),
    .gpmc_we_n(gpmc_we_n), .gpmc_oe_n(gpmc_oe_n),
    .gpmc_ad_out(gpmc_ad_out), .gpmc_ad_oe(gpmc_ad_oe), .gpmc_ad_in(gpmc_ad_in)
  );

  gpmc_sync_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RD_WAIT(0)) dut_0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_0), .req_ready(req_ready_0), .req_write(req_write_0),
    .req_addr(req_addr_0), .req_wdata(req_wdata_0),
    .rsp_valid(rsp_valid_0), .rsp_rdata(rsp_rdata_0),
    .gpmc_clk(gpmc_clk_0), .gpmc_cs_n(gpmc_cs_n_0), .gpmc_adv_n(gpmc_adv_n_0),
    .gpmc_we_n(gpmc_we_n_0), .gpmc_oe_n(gpmc_oe_n_0),
    .gpmc_ad_out(gpmc_ad_out_0), .gpmc_ad_oe(gpmc_ad_oe_0), .gpmc_ad_in(gpmc_ad_in_0)
  );

  int   checks = 0;
  int   errors = 0;
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  rsp_t exp_rsp_0[$];

  logic [15:0] mem [logic [15:0]];
  logic [15:0] resp_addr = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Caller is at a negedge; returns at the negedge following the accept edge.
  task automatic applyStimulus(input logic write, input logic [16:0] addr, input logic [15:0] wdata,
                               input logic [15:0] exp_rdata, input bit hold);
    int   n = 0;
    int   rw;
    bus_t b;
    rsp_t r;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errors++;
      $display("[TB] FAIL accept_timeout: req_ready never rose for addr 0x%0h", addr);
      req_valid = 1'b0;
      return;
    end
    checkOutput("accept_only_when_idle", exp_rsp.size(), 0);
    rw        = write ? 0 : RD_WAIT;
    b.write   = write;
    b.word    = addr[16:1];
    b.wdata   = wdata;
    r.rdata   = exp_rdata;
    r.accept  = clk_count + 1;
    r.lat_min = 2 * (3 + rw) - 1;
    r.lat_max = 2 * (3 + rw);
    exp_bus.push_back(b);
    exp_rsp.push_back(r);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((exp_rsp.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL idle_timeout: %0d responses still pending", exp_rsp.size());
    end
  endtask

  // Responder: drives AD while OE is asserted, otherwise a recognisable filler value.
  always @(negedge clk) begin
    if (!gpmc_oe_n && !gpmc_cs_n)
      gpmc_ad_in = mem.exists(resp_addr) ? mem[resp_addr] : 16'h0000;
    else
      gpmc_ad_in = 16'hDEAD;
    gpmc_ad_in_0 = !gpmc_oe_n_0 ? 16'h00A5 : 16'hFFFF;
  end

  // Bus monitor: one sample per GPMC cycle, taken while gpmc_clk is high.
  bus_t cur;
  int   oe_cycles = 0;
  int   cs_high = 0;
  bit   seen_access = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      oe_cycles   = 0;
      cs_high     = 0;
      seen_access = 1'b0;
    end else begin
      if (gpmc_ad_oe && !gpmc_oe_n) begin
        errors++;
        $display("[TB] FAIL bus_contention: ad_oe=1 while oe_n=0 at cycle %0d", clk_count);
      end
      if (gpmc_clk) begin
        if (!gpmc_oe_n) begin
          oe_cycles++;
          checkOutput("read_ad_oe", gpmc_ad_oe, 1'b0);
        end else if (oe_cycles != 0) begin
          checkOutput("oe_low_cycles", oe_cycles, RD_WAIT + 1);
          oe_cycles = 0;
        end
        if (gpmc_cs_n) cs_high++;
        if (!gpmc_adv_n) begin
          if (exp_bus.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_addr_phase: ad_out 0x%0h", gpmc_ad_out);
          end else begin
            cur = exp_bus.pop_front();
            checkOutput("addr_phase_ad_out", gpmc_ad_out, cur.word);
            checkOutput("addr_phase_cs_oe", {gpmc_cs_n, gpmc_ad_oe}, 2'b01);
            if (seen_access) checkOutput("cs_high_gap", (cs_high >= 1), 1'b1);
            seen_access = 1'b1;
            cs_high     = 0;
            resp_addr   = gpmc_ad_out;
          end
        end
        if (!gpmc_we_n) begin
          checkOutput("write_data_ad_out", gpmc_ad_out, cur.wdata);
          checkOutput("write_data_ad_oe", {gpmc_ad_oe, gpmc_adv_n}, 2'b11);
          mem[resp_addr] = gpmc_ad_out;
          $display("[TB] responder wr_en addr 0x%0h data 0x%0h", {resp_addr, 1'b0}, gpmc_ad_out);
        end
      end
    end
  end

  // Response monitor for the main DUT.
  rsp_t r_mon;
  bit   rsp_prev = 1'b0;

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_prev) begin
        errors++;
        $display("[TB] FAIL rsp_pulse_width: rsp_valid high for more than one clk");
      end else if (exp_rsp.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rsp: rsp_rdata 0x%0h", rsp_rdata);
      end else begin
        r_mon = exp_rsp.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, r_mon.rdata);
        checkRange("rsp_latency_clks", clk_count - r_mon.accept, r_mon.lat_min, r_mon.lat_max);
      end
    end
    rsp_prev = rsp_valid;
  end

  // Monitor for the RD_WAIT = 0 instance.
  rsp_t r_mon_0;
  int   oe_cycles_0 = 0;

  always @(negedge clk) begin
    if (!rst && gpmc_clk_0) begin
      if (!gpmc_oe_n_0) begin
        oe_cycles_0++;
      end else if (oe_cycles_0 != 0) begin
        checkOutput("oe_low_cycles_rw0", oe_cycles_0, 1);
        oe_cycles_0 = 0;
      end
    end
    if (rsp_valid_0) begin
      if (exp_rsp_0.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rsp_rw0: rsp_rdata 0x%0h", rsp_rdata_0);
      end else begin
        r_mon_0 = exp_rsp_0.pop_front();
        checkOutput("rsp_rdata_rw0", rsp_rdata_0, r_mon_0.rdata);
        checkRange("rsp_latency_rw0", clk_count - r_mon_0.accept, r_mon_0.lat_min, r_mon_0.lat_max);
      end
    end
  end

  initial begin
    rsp_t r0;
    int   n;
    mem[16'h0040] = 16'h1234;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_gpmc_clk", gpmc_clk, 1'b0);
    checkOutput("reset_ctrl_n", {gpmc_cs_n, gpmc_adv_n, gpmc_we_n, gpmc_oe_n}, 4'hF);
    checkOutput("reset_ad_oe", gpmc_ad_oe, 1'b0);
    checkOutput("reset_ad_out", gpmc_ad_out, 16'h0000);
    checkOutput("reset_rsp", {rsp_valid, rsp_rdata}, 17'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", req_ready, 1'b1);

    applyStimulus(1'b1, 17'h00014, 16'hBEEF, 16'h0000, 1'b0); waitIdle();
    applyStimulus(1'b0, 17'h00080, 16'h0000, 16'h1234, 1'b0); waitIdle();
    applyStimulus(1'b0, 17'h00014, 16'h0000, 16'hBEEF, 1'b0); waitIdle();
    applyStimulus(1'b1, 17'h1FFFF, 16'h5A5A, 16'hBEEF, 1'b0); waitIdle();
    applyStimulus(1'b0, 17'h1FFFE, 16'h0000, 16'h5A5A, 1'b0); waitIdle();
    applyStimulus(1'b1, 17'h00002, 16'hC3C3, 16'h5A5A, 1'b1);
    applyStimulus(1'b0, 17'h00002, 16'h0000, 16'hC3C3, 1'b0); waitIdle();

    // RD_WAIT = 0 instance: single read captured on the first DATA fall edge.
    req_write_0 = 1'b0;
    req_addr_0  = 17'h00080;
    req_valid_0 = 1'b1;
    n = 0;
    while (!req_ready_0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_0) begin
      errors++;
      $display("[TB] FAIL accept_timeout_rw0: req_ready never rose");
    end else begin
      r0.rdata   = 16'h00A5;
      r0.accept  = clk_count + 1;
      r0.lat_min = 5;
      r0.lat_max = 6;
      exp_rsp_0.push_back(r0);
    end
    @(negedge clk);
    req_valid_0 = 1'b0;
    n = 0;
    while (exp_rsp_0.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL rsp_timeout_rw0: no response");
    end

    // Reset in the middle of a read DATA phase.
    applyStimulus(1'b0, 17'h00080, 16'h0000, 16'h1234, 1'b0);
    n = 0;
    while (gpmc_oe_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("oe_asserted_before_reset", gpmc_oe_n, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset_cs_n", gpmc_cs_n, 1'b1);
    checkOutput("midreset_ad_oe", gpmc_ad_oe, 1'b0);
    checkOutput("midreset_gpmc_clk", gpmc_clk, 1'b0);
    checkOutput("midreset_oe_n", gpmc_oe_n, 1'b1);
    exp_rsp.delete();
    exp_bus.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_midreset", req_ready, 1'b1);
    checkOutput("rdata_cleared_by_reset", rsp_rdata, 16'h0000);
    repeat (20) @(negedge clk);

    applyStimulus(1'b0, 17'h00014, 16'h0000, 16'hBEEF, 1'b0); waitIdle();

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
